// File: rtl/dense_neuron_pkg.sv
// Shared types and helpers for the dense_neuron_mac neuron engine.
package dense_neuron_pkg;

  typedef enum logic [1:0] {IDLE, ACC, OUT, DONE} state_t;

  localparam int DEF_IN_FRAC  = 8;
  localparam int DEF_W_FRAC   = 8;
  localparam int DEF_OUT_FRAC = 8;

  // Index width for an n-entry table, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_neuron_requant.sv
// Accumulator-to-output requantiser: arithmetic shift, saturate, optional ReLU.
// Optional ReLU clamp is enabled by defining RELU_EN.
module dense_neuron_requant #(
  parameter int ACC_W = 40,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] q
);

  logic signed [ACC_W-1:0] y;
  logic                    pos_ovf;
  logic                    neg_ovf;

  assign y = acc >>> SHIFT;

  // Out of range whenever the bits above the output sign differ from the sign.
  assign pos_ovf = !y[ACC_W-1] && (|y[ACC_W-2:OUT_W-1]);
  assign neg_ovf =  y[ACC_W-1] && !(&y[ACC_W-2:OUT_W-1]);

  always_comb begin
    q = y[OUT_W-1:0];
    if (pos_ovf)      q = {1'b0, {(OUT_W-1){1'b1}}};
    else if (neg_ovf) q = {1'b1, {(OUT_W-1){1'b0}}};
`ifdef RELU_EN
    if (q[OUT_W-1]) q = '0;
`else
    q = q;
`endif
  end

endmodule

// File: rtl/dense_neuron_mac.sv
// Single-neuron dense-layer MAC engine with ap_ctrl_hs handshake.
// Define RELU_EN to clamp negative outputs to zero.
module dense_neuron_mac
  import dense_neuron_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int IN_W     = 16,
  parameter int IN_FRAC  = DEF_IN_FRAC,
  parameter int W_W      = 16,
  parameter int W_FRAC   = DEF_W_FRAC,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = DEF_OUT_FRAC
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic [IN_W-1:0]         input_V,
  input  logic                    input_V_ap_vld,
  output logic [OUT_W-1:0]        layer_out_V,
  output logic                    layer_out_V_ap_vld,
  input  logic                    wt_we,
  input  logic [idx_w(N_IN)-1:0]  wt_addr,
  input  logic [W_W-1:0]          wt_data,
  input  logic                    bias_we,
  input  logic [ACC_W-1:0]        bias_data
);

  localparam int AW    = idx_w(N_IN);
  localparam int SHIFT = IN_FRAC + W_FRAC - OUT_FRAC;

  if (N_IN < 2 || ACC_W < IN_W + W_W + $clog2(N_IN) + 1 ||
      OUT_FRAC > IN_FRAC + W_FRAC || ACC_W <= OUT_W) begin : g_bad_params
    $error("dense_neuron_mac: illegal parameter set");
  end

  state_t                      state;
  logic signed [W_W-1:0]       weights [N_IN];
  logic        [ACC_W-1:0]     bias;
  logic signed [ACC_W-1:0]     acc;
  logic        [AW-1:0]        idx;
  logic signed [W_W-1:0]       cur_w;
  logic signed [IN_W+W_W-1:0]  prod;
  logic        [OUT_W-1:0]     q;
  logic                        last;

  always_comb begin
    cur_w = '0;
    for (int i = 0; i < N_IN; i++)
      if (idx == AW'(i)) cur_w = weights[i];
  end

  assign prod = $signed(input_V) * cur_w;
  assign last = (idx == AW'(N_IN - 1));

  assign ap_ready           = (state == ACC) && input_V_ap_vld && last;
  assign ap_idle            = (state == IDLE);
  assign ap_done            = (state == DONE);
  assign layer_out_V_ap_vld = ap_done;

  dense_neuron_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc (acc),
    .q   (q)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= IDLE;
      acc         <= '0;
      idx         <= '0;
      bias        <= '0;
      layer_out_V <= '0;
      for (int i = 0; i < N_IN; i++) weights[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Table writes are only honoured while idle; decode drops out-of-range addresses.
          if (wt_we)
            for (int i = 0; i < N_IN; i++)
              if (wt_addr == AW'(i)) weights[i] <= wt_data;
          if (bias_we) bias <= bias_data;
          if (ap_start) begin
            acc   <= $signed(bias);
            idx   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (input_V_ap_vld) begin
            acc <= acc + ACC_W'(prod);
            if (last) state <= OUT;
            else      idx   <= idx + AW'(1);
          end
        end
        OUT: begin
          layer_out_V <= q;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
